uart_stream_bridge: RTL and testbench

//  Host-side initiator for the UART core's CSN/WEN/OEN byte interface. Accepts a valid/ready
//  TX byte stream and issues core writes when TXRDY=1. Polls RXRDY, issues core reads and

---
 rtl/uart_bridge_pkg.sv | 15 +
 rtl/uart_byte_slot.sv | 55 +++++
 rtl/uart_stream_bridge.sv | 169 ++++++++++++++++
 tb/tb_uart_stream_bridge.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART stream bridge: FSM encoding and err_sticky bit positions.
package uart_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2,
      StGuard = 2'd3
   } state_e;

   localparam int unsigned ERR_PAR = 0;
   localparam int unsigned ERR_FRM = 1;
   localparam int unsigned ERR_OVF = 2;

endpackage

// File: rtl/uart_byte_slot.sv
// One-entry valid/ready holding register for an 8-bit byte plus a 2-bit tag.
module uart_byte_slot (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       in_valid_i,
   input  logic [7:0] in_data_i,
   input  logic [1:0] in_tag_i,
   output logic       in_ready_o,
   output logic       out_valid_o,
   output logic [7:0] out_data_o,
   output logic [1:0] out_tag_o,
   input  logic       out_ready_i
);

   logic       full_q, full_d;
   logic [7:0] data_q, data_d;
   logic [1:0] tag_q, tag_d;
   logic       load, pop;

   // A pop in the same cycle frees the entry, so a new byte may be taken at once.
   assign in_ready_o = !full_q || out_ready_i;
   assign load       = in_valid_i && in_ready_o;
   assign pop        = full_q && out_ready_i;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (pop) begin
         full_d = 1'b0;
      end
      if (load) begin
         full_d = 1'b1;
         data_d = in_data_i;
         tag_d  = in_tag_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         data_q <= 8'h00;
         tag_q  <= 2'b00;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         tag_q  <= tag_d;
      end
   end

   assign out_valid_o = full_q;
   assign out_data_o  = data_q;
   assign out_tag_o   = tag_q;

endmodule

// File: rtl/uart_stream_bridge.sv
// Host-side initiator for the UART core byte interface: TX stream -> core writes,
// polled core reads -> RX stream, with arbitration, guard spacing and sticky errors.
module uart_stream_bridge
   import uart_bridge_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter bit          ERR_DROP     = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [1:0] rx_err,
   output logic [2:0] err_sticky,
   input  logic       err_clr,
   output logic       busy,
   output logic       CSN,
   output logic       WEN,
   output logic       OEN,
   output logic [7:0] UART_DATA_IN,
   input  logic [7:0] UART_DATA_OUT,
   input  logic       TXRDY,
   input  logic       RXRDY,
   input  logic       PARITY_ERR,
   input  logic       FRAMING_ERR,
   input  logic       OVERFLOW
);

   localparam logic [2:0] GuardLast = 3'(GUARD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] guard_cnt_q, guard_cnt_d;
   logic       last_wr_q, last_wr_d;
   logic       csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
   logic [7:0] dout_q, dout_d;
   logic       ovf_q;
   logic [2:0] sticky_q, sticky_d;

   logic       tx_full, tx_pop;
   logic [7:0] tx_slot_data;
   logic [1:0] tx_tag_unused;
   logic       rx_in_ready, rx_load, rd_close;
   logic [1:0] rx_flags;
   logic       tx_cand, rx_cand;

   assign tx_pop   = (state_q == StWrite);
   assign rd_close = (state_q == StRead);
   assign rx_flags = {FRAMING_ERR, PARITY_ERR};
   assign rx_load  = rd_close && !(ERR_DROP && (rx_flags != 2'b00));
   assign tx_cand  = tx_full && TXRDY;
   assign rx_cand  = RXRDY && rx_in_ready;

   uart_byte_slot u_tx_slot (
      .clk_i       (CLK),
      .rst_ni      (RESET_N),
      .in_valid_i  (tx_valid),
      .in_data_i   (tx_data),
      .in_tag_i    (2'b00),
      .in_ready_o  (tx_ready),
      .out_valid_o (tx_full),
      .out_data_o  (tx_slot_data),
      .out_tag_o   (tx_tag_unused),
      .out_ready_i (tx_pop)
   );

   uart_byte_slot u_rx_slot (
      .clk_i       (CLK),
      .rst_ni      (RESET_N),
      .in_valid_i  (rx_load),
      .in_data_i   (UART_DATA_OUT),
      .in_tag_i    (rx_flags),
      .in_ready_o  (rx_in_ready),
      .out_valid_o (rx_valid),
      .out_data_o  (rx_data),
      .out_tag_o   (rx_err),
      .out_ready_i (rx_ready)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= StIdle;
         guard_cnt_q <= 3'd0;
         last_wr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         guard_cnt_q <= guard_cnt_d;
         last_wr_q   <= last_wr_d;
      end
   end

   // last_wr_q resets to "read served last", so the first contention goes to the write.
   always_comb begin
      state_d     = state_q;
      guard_cnt_d = guard_cnt_q;
      last_wr_d   = last_wr_q;
      case (state_q)
         StIdle: begin
            if (tx_cand && (!rx_cand || !last_wr_q)) begin
               state_d   = StWrite;
               last_wr_d = 1'b1;
            end else if (rx_cand) begin
               state_d   = StRead;
               last_wr_d = 1'b0;
            end
         end
         StWrite, StRead: begin
            state_d     = StGuard;
            guard_cnt_d = GuardLast;
         end
         StGuard: begin
            if (guard_cnt_q == 3'd0) begin
               state_d = StIdle;
            end else begin
               guard_cnt_d = guard_cnt_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Strobes are decoded from the next state and registered, so they track state_q glitch-free.
   always_comb begin
      csn_d  = !((state_d == StWrite) || (state_d == StRead));
      wen_d  = (state_d != StWrite);
      oen_d  = (state_d != StRead);
      dout_d = (state_d == StWrite) ? tx_slot_data : dout_q;
   end

   always_comb begin
      sticky_d = err_clr ? 3'b000 : sticky_q;
      if (rd_close) begin
         sticky_d[ERR_PAR] = sticky_d[ERR_PAR] | PARITY_ERR;
         sticky_d[ERR_FRM] = sticky_d[ERR_FRM] | FRAMING_ERR;
      end
      if (OVERFLOW && !ovf_q) begin
         sticky_d[ERR_OVF] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         csn_q    <= 1'b1;
         wen_q    <= 1'b1;
         oen_q    <= 1'b1;
         dout_q   <= 8'h00;
         ovf_q    <= 1'b0;
         sticky_q <= 3'b000;
      end else begin
         csn_q    <= csn_d;
         wen_q    <= wen_d;
         oen_q    <= oen_d;
         dout_q   <= dout_d;
         ovf_q    <= OVERFLOW;
         sticky_q <= sticky_d;
      end
   end

   assign CSN          = csn_q;
   assign WEN          = wen_q;
   assign OEN          = oen_q;
   assign UART_DATA_IN = dout_q;
   assign err_sticky   = sticky_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge; a second instance runs with ERR_DROP=0.
module tb_uart_stream_bridge;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] tx_data;
   logic       tx_valid, rx_ready, err_clr;
   logic [7:0] UART_DATA_OUT;
   logic       TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW;

   logic       tx_ready, rx_valid, busy, CSN, WEN, OEN;
   logic [7:0] rx_data, UART_DATA_IN;
   logic [1:0] rx_err;
   logic [2:0] err_sticky;

   logic       tx_ready0, rx_valid0, busy0, csn0, wen0, oen0;
   logic [7:0] rx_data0, dout0;
   logic [1:0] rx_err0;
   logic [2:0] err_sticky0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic       csn;
      logic       wen;
      logic       oen;
      logic [7:0] d;
   } strobe_t;
   strobe_t slog[$];

   always #5 CLK = ~CLK;

   uart_stream_bridge #(.GUARD_CYCLES(2), .ERR_DROP(1'b1)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_err(rx_err), .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy),
      .CSN(CSN), .WEN(WEN), .OEN(OEN), .UART_DATA_IN(UART_DATA_IN),
      .UART_DATA_OUT(UART_DATA_OUT), .TXRDY(TXRDY), .RXRDY(RXRDY),
      .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW)
   );

   uart_stream_bridge #(.GUARD_CYCLES(2), .ERR_DROP(1'b0)) u_dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
      .rx_err(rx_err0), .err_sticky(err_sticky0), .err_clr(err_clr), .busy(busy0),
      .CSN(csn0), .WEN(wen0), .OEN(oen0), .UART_DATA_IN(dout0),
      .UART_DATA_OUT(UART_DATA_OUT), .TXRDY(TXRDY), .RXRDY(RXRDY),
      .PARITY_ERR(PARITY_ERR), .FRAMING_ERR(FRAMING_ERR), .OVERFLOW(OVERFLOW)
   );

   always @(posedge CLK) cyc <= cyc + 1;

   // Log every strobe cycle and check the strobe legality rules there.
   always @(posedge CLK) begin
      #1;
      if (!CSN || !WEN || !OEN) begin
         slog.push_back('{cyc, CSN, WEN, OEN, UART_DATA_IN});
         vectors++;
         if (CSN !== 1'b0 || WEN === OEN) begin
            miscompares++;
            $display("FAIL strobe_rule: CSN=%b WEN=%b OEN=%b, required CSN=0 with one of WEN/OEN",
                     CSN, WEN, OEN);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output int acc);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         miscompares++;
         $display("FAIL send_timeout: tx_ready stayed 0, required 1 within 20 cycles");
      end
      acc = cyc;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({CSN, WEN, OEN} !== 3'b111) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b, required 111", {CSN, WEN, OEN});
      end
      vectors++;
      if ({UART_DATA_IN, rx_data} !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_data: got %h/%h, required 00/00", UART_DATA_IN, rx_data);
      end
      vectors++;
      if ({rx_valid, rx_err, err_sticky, busy, tx_ready} !== 8'b0_00_000_0_1) begin
         miscompares++;
         $display("FAIL reset_flags: got %b, required 00000001",
                  {rx_valid, rx_err, err_sticky, busy, tx_ready});
      end
   endtask

   task automatic test_tx_single();
      int acc;
      slog.delete();
      TXRDY = 1'b1;
      send_byte(8'hA5, acc);
      vectors++;
      if (tx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL tx_full_ready: got %b, required 0", tx_ready);
      end
      repeat (8) tick();
      vectors++;
      if (slog.size() != 1) begin
         miscompares++;
         $display("FAIL tx_strobe_count: got %0d, required 1", slog.size());
      end else begin
         vectors++;
         if ({slog[0].csn, slog[0].wen, slog[0].oen, slog[0].d} !== {3'b001, 8'hA5}) begin
            miscompares++;
            $display("FAIL tx_write: got %b/%h, required 001/a5",
                     {slog[0].csn, slog[0].wen, slog[0].oen}, slog[0].d);
         end
         vectors++;
         if (slog[0].cyc != acc + 2) begin
            miscompares++;
            $display("FAIL tx_latency: got %0d, required %0d", slog[0].cyc - acc, 2);
         end
      end
   endtask

   task automatic test_rx_single();
      UART_DATA_OUT = 8'h3C;
      rx_ready      = 1'b1;
      RXRDY         = 1'b1;
      tick();
      RXRDY = 1'b0;
      vectors++;
      if ({CSN, WEN, OEN} !== 3'b010) begin
         miscompares++;
         $display("FAIL rx_read_strobe: got %b, required 010", {CSN, WEN, OEN});
      end
      tick();
      vectors++;
      if ({rx_valid, rx_data, rx_err, CSN} !== {1'b1, 8'h3C, 2'b00, 1'b1}) begin
         miscompares++;
         $display("FAIL rx_deliver: got v=%b d=%h e=%b csn=%b, required v=1 d=3c e=00 csn=1",
                  rx_valid, rx_data, rx_err, CSN);
      end
      tick();
      vectors++;
      if (rx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rx_consumed: got %b, required 0", rx_valid);
      end
      repeat (4) tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] tbl [4];
      int  idx = 0;
      int  n = 0;
      logic fire;
      tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
      slog.delete();
      UART_DATA_OUT = 8'h5A;
      rx_ready = 1'b1;
      TXRDY    = 1'b1;
      tx_data  = tbl[0];
      tx_valid = 1'b1;
      while (slog.size() < 8 && n < 80) begin
         fire = tx_valid && tx_ready;
         tick();
         n++;
         RXRDY = 1'b1;
         if (fire) begin
            idx++;
            if (idx < 4) tx_data = tbl[idx];
            else tx_valid = 1'b0;
         end
      end
      RXRDY    = 1'b0;
      tx_valid = 1'b0;
      vectors++;
      if (slog.size() < 8) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d strobes, required 8", slog.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if ((i % 2) == 0) begin
               if (slog[i].wen !== 1'b0 || slog[i].d !== tbl[i / 2]) begin
                  miscompares++;
                  $display("FAIL b2b_write%0d: got wen=%b d=%h, required wen=0 d=%h",
                           i, slog[i].wen, slog[i].d, tbl[i / 2]);
               end
            end else if (slog[i].oen !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_read%0d: got oen=%b, required 0", i, slog[i].oen);
            end
            if (i > 0) begin
               vectors++;
               if (slog[i].cyc - slog[i - 1].cyc != 4) begin
                  miscompares++;
                  $display("FAIL b2b_spacing%0d: got %0d, required 4",
                           i, slog[i].cyc - slog[i - 1].cyc);
               end
            end
         end
      end
      repeat (10) tick();
   endtask

   task automatic test_rx_backpressure();
      int h;
      slog.delete();
      UART_DATA_OUT = 8'h77;
      rx_ready = 1'b0;
      RXRDY    = 1'b1;
      repeat (12) tick();
      vectors++;
      if (slog.size() != 1 || rx_valid !== 1'b1 || rx_data !== 8'h77) begin
         miscompares++;
         $display("FAIL bp_hold: got reads=%0d v=%b d=%h, required reads=1 v=1 d=77",
                  slog.size(), rx_valid, rx_data);
      end
      UART_DATA_OUT = 8'h78;
      rx_ready = 1'b1;
      h = cyc;
      tick();
      RXRDY = 1'b0;
      repeat (8) tick();
      vectors++;
      if (slog.size() != 2) begin
         miscompares++;
         $display("FAIL bp_second_count: got %0d, required 2", slog.size());
      end else begin
         vectors++;
         if (slog[1].oen !== 1'b0 || slog[1].cyc != h + 1) begin
            miscompares++;
            $display("FAIL bp_second_read: got oen=%b at +%0d, required oen=0 at +1",
                     slog[1].oen, slog[1].cyc - h);
         end
      end
   endtask

   task automatic test_errors();
      rx_ready      = 1'b0;
      UART_DATA_OUT = 8'h99;
      PARITY_ERR    = 1'b1;
      RXRDY         = 1'b1;
      tick();
      RXRDY = 1'b0;
      tick();
      PARITY_ERR = 1'b0;
      vectors++;
      if (rx_valid !== 1'b0 || err_sticky !== 3'b001) begin
         miscompares++;
         $display("FAIL par_drop: got v=%b sticky=%b, required v=0 sticky=001",
                  rx_valid, err_sticky);
      end
      vectors++;
      if ({rx_valid0, rx_err0, rx_data0, err_sticky0} !== {1'b1, 2'b01, 8'h99, 3'b001}) begin
         miscompares++;
         $display("FAIL par_keep: got v=%b e=%b d=%h s=%b, required v=1 e=01 d=99 s=001",
                  rx_valid0, rx_err0, rx_data0, err_sticky0);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vectors++;
      if (err_sticky !== 3'b000 || err_sticky0 !== 3'b000) begin
         miscompares++;
         $display("FAIL err_clear: got %b/%b, required 000/000", err_sticky, err_sticky0);
      end
      rx_ready = 1'b1;
      repeat (4) tick();
      UART_DATA_OUT = 8'h42;
      FRAMING_ERR   = 1'b1;
      RXRDY         = 1'b1;
      tick();
      RXRDY = 1'b0;
      tick();
      FRAMING_ERR = 1'b0;
      vectors++;
      if (err_sticky !== 3'b010 || rx_valid !== 1'b0 || {rx_valid0, rx_err0} !== 3'b110) begin
         miscompares++;
         $display("FAIL frm: got s=%b v=%b v0=%b e0=%b, required s=010 v=0 v0=1 e0=10",
                  err_sticky, rx_valid, rx_valid0, rx_err0);
      end
      OVERFLOW = 1'b1;
      err_clr  = 1'b1;
      tick();
      vectors++;
      if (err_sticky !== 3'b100) begin
         miscompares++;
         $display("FAIL ovf_set_wins: got %b, required 100", err_sticky);
      end
      tick();
      vectors++;
      if (err_sticky !== 3'b000) begin
         miscompares++;
         $display("FAIL ovf_level_only: got %b, required 000", err_sticky);
      end
      err_clr  = 1'b0;
      OVERFLOW = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid_write();
      int acc;
      TXRDY = 1'b1;
      send_byte(8'h11, acc);
      tick();
      vectors++;
      if (WEN !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_pre_write: got WEN=%b, required 0", WEN);
      end
      RESET_N = 1'b0;
      #1;
      vectors++;
      if ({CSN, WEN} !== 2'b11) begin
         miscompares++;
         $display("FAIL rst_async_strobe: got %b, required 11", {CSN, WEN});
      end
      #2;
      RESET_N = 1'b1;
      tick();
      vectors++;
      if ({tx_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL rst_release: got ready/busy=%b, required 10", {tx_ready, busy});
      end
      TXRDY = 1'b0;
      send_byte(8'h22, acc);
      vectors++;
      if (tx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_held: got tx_ready=%b, required 0", tx_ready);
      end
      RESET_N = 1'b0;
      #2;
      RESET_N = 1'b1;
      slog.delete();
      TXRDY = 1'b1;
      repeat (8) tick();
      vectors++;
      if (slog.size() != 0 || tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_byte_lost: got writes=%0d ready=%b, required 0/1",
                  slog.size(), tx_ready);
      end
   endtask

   initial begin
      RESET_N       = 1'b0;
      tx_data       = 8'h00;
      tx_valid      = 1'b0;
      rx_ready      = 1'b0;
      err_clr       = 1'b0;
      UART_DATA_OUT = 8'h00;
      TXRDY         = 1'b0;
      RXRDY         = 1'b0;
      PARITY_ERR    = 1'b0;
      FRAMING_ERR   = 1'b0;
      OVERFLOW      = 1'b0;
      tick();
      tick();
      test_reset();
      RESET_N = 1'b1;
      tick();
      test_tx_single();
      test_rx_single();
      test_back_to_back();
      test_rx_backpressure();
      test_errors();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
